// File: rtl/washer_pkg.sv
// Shared washer types: operating modes, supervisor states and fault codes.
package washer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_FILL  = 2'b01,
        MODE_DRAIN = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } lfs_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_STALL   = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_LEAK    = 2'b11
    } flow_err_e;

endpackage

// File: rtl/level_delta_check.sv
// Combinational progress/leak classification of the current level against the
// reference level for one operating mode. All arithmetic is one bit wider than level.
module level_delta_check
    import washer_pkg::*;
#(
    parameter int LEVEL_W   = 10,
    parameter int THRESHOLD = 10,
    parameter int HOLD_BAND = 20
) (
    input  mode_e              mode,
    input  logic [LEVEL_W-1:0] ref_lvl,
    input  logic [LEVEL_W-1:0] level,
    output logic               progress,
    output logic               leak
);

    localparam logic [LEVEL_W:0] THR  = (LEVEL_W+1)'(THRESHOLD);
    localparam logic [LEVEL_W:0] BAND = (LEVEL_W+1)'(HOLD_BAND);

    logic [LEVEL_W:0] lvl_x;
    logic [LEVEL_W:0] ref_x;
    logic [LEVEL_W:0] abs_diff;

    always_comb begin
        lvl_x    = {1'b0, level};
        ref_x    = {1'b0, ref_lvl};
        abs_diff = (lvl_x >= ref_x) ? (lvl_x - ref_x) : (ref_x - lvl_x);
        progress = 1'b0;
        leak     = 1'b0;
        case (mode)
            MODE_FILL: begin
                leak     = (lvl_x + THR) < ref_x;
                progress = lvl_x >= (ref_x + THR);
            end
            MODE_DRAIN: begin
                leak     = lvl_x > (ref_x + THR);
                // Guard keeps ref-THR from underflowing near empty.
                progress = (ref_x >= THR) && (lvl_x <= (ref_x - THR));
            end
            MODE_HOLD: begin
                leak = abs_diff > BAND;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/level_flow_supervisor.sv
// Supervises one fill/drain/hold operation: detects completion, stall,
// leak/backflow and overall timeout. All outputs are registered.
module level_flow_supervisor
    import washer_pkg::*;
#(
    parameter int LEVEL_W      = 10,
    parameter int THRESHOLD    = 10,
    parameter int STALL_CYCLES = 5,
    parameter int MAX_CYCLES   = 1000,
    parameter int HOLD_BAND    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] target,
    input  logic               start,
    input  logic               abort,
    input  logic               clear_err,
    output logic               busy,
    output logic               done,
    output logic               error_flag,
    output logic [1:0]         error_code
);

    localparam int TW = $clog2(MAX_CYCLES) + 1;
    localparam int SW = $clog2(STALL_CYCLES) + 1;
    localparam logic [TW-1:0] TOT_LAST   = TW'(MAX_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

    lfs_state_e         state, state_n;
    mode_e              mode_q, mode_n;
    logic [LEVEL_W-1:0] target_q, target_n;
    logic [LEVEL_W-1:0] ref_lvl, ref_n;
    logic [SW-1:0]      stall_cnt, stall_n;
    logic [TW-1:0]      total_cnt, total_n;
    flow_err_e          code_n;

    logic progress;
    logic leak;
    logic reached;

    level_delta_check #(
        .LEVEL_W  (LEVEL_W),
        .THRESHOLD(THRESHOLD),
        .HOLD_BAND(HOLD_BAND)
    ) u_delta (
        .mode    (mode_q),
        .ref_lvl (ref_lvl),
        .level   (level),
        .progress(progress),
        .leak    (leak)
    );

    assign reached = ((mode_q == MODE_FILL)  && (level >= target_q)) ||
                     ((mode_q == MODE_DRAIN) && (level <= target_q));

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        target_n = target_q;
        ref_n    = ref_lvl;
        stall_n  = stall_cnt;
        total_n  = total_cnt;
        code_n   = flow_err_e'(error_code);
        case (state)
            ST_IDLE, ST_DONE: begin
                if ((state == ST_DONE) && abort) begin
                    state_n = ST_IDLE;
                end else if (start && (mode != MODE_IDLE)) begin
                    state_n  = ST_RUN;
                    mode_n   = mode_e'(mode);
                    target_n = target;
                    ref_n    = level;
                    stall_n  = '0;
                    total_n  = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (reached) begin
                    state_n = ST_DONE;
                end else if (leak) begin
                    state_n = ST_FAULT;
                    code_n  = ERR_LEAK;
                end else if (mode_q != MODE_HOLD) begin
                    total_n = (total_cnt == '1) ? total_cnt : total_cnt + 1'b1;
                    if (progress) begin
                        ref_n   = level;
                        stall_n = '0;
                    end
                    // Timeout outranks stall, and fires even while progressing.
                    if (total_cnt == TOT_LAST) begin
                        state_n = ST_FAULT;
                        code_n  = ERR_TIMEOUT;
                    end else if (!progress) begin
                        if (stall_cnt == STALL_LAST) begin
                            state_n = ST_FAULT;
                            code_n  = ERR_STALL;
                        end else begin
                            stall_n = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    state_n = ST_IDLE;
                    code_n  = ERR_NONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_IDLE;
            target_q   <= '0;
            ref_lvl    <= '0;
            stall_cnt  <= '0;
            total_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error_flag <= 1'b0;
            error_code <= 2'b00;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            target_q   <= target_n;
            ref_lvl    <= ref_n;
            stall_cnt  <= stall_n;
            total_cnt  <= total_n;
            busy       <= (state_n == ST_RUN);
            done       <= (state_n == ST_DONE);
            error_flag <= (state_n == ST_FAULT);
            error_code <= code_n;
        end
    end

endmodule

// File: tb/tb_level_flow_supervisor.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_level_flow_supervisor;

    localparam int LW   = 10;
    localparam int THR  = 10;
    localparam int SC   = 5;
    localparam int BAND = 20;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2, PH_FAULT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [LW-1:0] level;
    logic [1:0]    mode;
    logic [LW-1:0] target;
    logic          start, abort, clear_err;
    logic          busy0, done0, flag0;
    logic [1:0]    code0;
    logic          busy1, done1, flag1;
    logic [1:0]    code1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = default limits, 1 = MAX_CYCLES of 8.
    int maxc [2] = '{1000, 8};
    int m_ph [2];
    int m_code [2];
    int m_mode [2];
    int m_tgt [2];
    int m_ref [2];
    int m_el [2];
    int m_idle [2];

    level_flow_supervisor #(
        .LEVEL_W(LW), .THRESHOLD(THR), .STALL_CYCLES(SC), .MAX_CYCLES(1000), .HOLD_BAND(BAND)
    ) dut0 (
        .clk(clk), .reset(reset), .level(level), .mode(mode), .target(target),
        .start(start), .abort(abort), .clear_err(clear_err),
        .busy(busy0), .done(done0), .error_flag(flag0), .error_code(code0)
    );

    level_flow_supervisor #(
        .LEVEL_W(LW), .THRESHOLD(THR), .STALL_CYCLES(SC), .MAX_CYCLES(8), .HOLD_BAND(BAND)
    ) dut1 (
        .clk(clk), .reset(reset), .level(level), .mode(mode), .target(target),
        .start(start), .abort(abort), .clear_err(clear_err),
        .busy(busy1), .done(done1), .error_flag(flag1), .error_code(code1)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs(input int i);
        return (i == 0) ? {busy0, done0, flag0, code0} : {busy1, done1, flag1, code1};
    endfunction

    function automatic logic [4:0] expv(input int i);
        return {m_ph[i] == PH_RUN, m_ph[i] == PH_DONE, m_ph[i] == PH_FAULT, 2'(m_code[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = PH_IDLE; m_code[i] = 0; m_mode[i] = 0; m_tgt[i] = 0;
            m_ref[i] = 0; m_el[i] = 0; m_idle[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int  lv, md, diff;
        bit  reach, lk, prog;
        lv = int'(level);
        case (m_ph[i])
            PH_FAULT: if (clear_err) begin m_ph[i] = PH_IDLE; m_code[i] = 0; end
            PH_RUN: begin
                md    = m_mode[i];
                reach = (md == 1 && lv >= m_tgt[i]) || (md == 2 && lv <= m_tgt[i]);
                diff  = (lv > m_ref[i]) ? lv - m_ref[i] : m_ref[i] - lv;
                if (md == 3)      lk = diff > BAND;
                else if (md == 1) lk = lv + THR < m_ref[i];
                else              lk = lv > m_ref[i] + THR;
                if (abort) m_ph[i] = PH_IDLE;
                else if (reach) m_ph[i] = PH_DONE;
                else if (lk) begin m_ph[i] = PH_FAULT; m_code[i] = 3; end
                else if (md != 3) begin
                    prog = (md == 1) ? (lv >= m_ref[i] + THR) : (lv <= m_ref[i] - THR);
                    m_el[i]++;
                    if (prog) begin m_ref[i] = lv; m_idle[i] = 0; end
                    else m_idle[i]++;
                    if (m_el[i] >= maxc[i]) begin m_ph[i] = PH_FAULT; m_code[i] = 2; end
                    else if (m_idle[i] >= SC) begin m_ph[i] = PH_FAULT; m_code[i] = 1; end
                end
            end
            default: begin
                if (m_ph[i] == PH_DONE && abort) m_ph[i] = PH_IDLE;
                else if (start && mode != 2'b00) begin
                    m_ph[i] = PH_RUN; m_mode[i] = int'(mode); m_tgt[i] = int'(target);
                    m_ref[i] = lv; m_el[i] = 0; m_idle[i] = 0;
                end
            end
        endcase
    endtask

    task automatic tick(input bit s, input bit a, input bit c, input int lv, input int md, input int tg);
        start = s; abort = a; clear_err = c;
        level = LW'(lv); mode = 2'(md); target = LW'(tg);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; clear_err = 0; level = '0; mode = '0; target = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 5'b00000) begin
                $display("FAIL reset dut%0d: got %b want 00000", i, obs(i)); n_bad++;
            end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_fill_progress();
        tick(1, 0, 0, 100, 1, 200);
        n_cmp++;
        if (obs(0) !== 5'b10000) begin $display("FAIL fill_start: got %b want 10000", obs(0)); n_bad++; end
        for (int k = 1; k <= 9; k++) begin
            tick(0, 0, 0, 100 + 12 * k, 1, 200);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    $display("FAIL fill_model dut%0d cyc%0d: got %b want %b", i, k, obs(i), expv(i)); n_bad++;
                end
            end
        end
        n_cmp++;
        if (obs(0) !== 5'b01000) begin $display("FAIL fill_done: got %b want 01000", obs(0)); n_bad++; end
        n_cmp++;
        if (obs(1) !== 5'b00110) begin $display("FAIL fill_short_timeout: got %b want 00110", obs(1)); n_bad++; end
        tick(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 5'b00000) begin $display("FAIL fill_cleanup dut%0d: got %b want 00000", i, obs(i)); n_bad++; end
        end
    endtask

    task automatic test_stall_clear(input int md, input int lv, input int tg, input string nm);
        tick(1, 0, 0, lv, md, tg);
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0, lv, md, tg);
            n_cmp++;
            if (obs(0) !== expv(0)) begin
                $display("FAIL %s_model cyc%0d: got %b want %b", nm, k, obs(0), expv(0)); n_bad++;
            end
            if (k == 4) begin
                n_cmp++;
                if (obs(0) !== 5'b10000) begin $display("FAIL %s_busy4: got %b want 10000", nm, obs(0)); n_bad++; end
            end
        end
        n_cmp++;
        if (obs(0) !== 5'b00101) begin $display("FAIL %s_stall: got %b want 00101", nm, obs(0)); n_bad++; end
        tick(0, 0, 1, lv, 0, 0);
        n_cmp++;
        if (obs(0) !== 5'b00000) begin $display("FAIL %s_clear: got %b want 00000", nm, obs(0)); n_bad++; end
    endtask

    task automatic test_leak();
        tick(1, 0, 0, 300, 1, 400);
        tick(0, 0, 0, 285, 1, 400);
        n_cmp++;
        if (obs(0) !== 5'b00111) begin $display("FAIL leak_fill: got %b want 00111", obs(0)); n_bad++; end
        tick(0, 1, 1, 285, 0, 0);
        tick(1, 0, 0, 500, 3, 0);
        tick(0, 0, 0, 480, 3, 0);
        n_cmp++;
        if (obs(0) !== 5'b10000) begin $display("FAIL hold_in_band: got %b want 10000", obs(0)); n_bad++; end
        tick(0, 0, 0, 521, 3, 0);
        n_cmp++;
        if (obs(0) !== 5'b00111) begin $display("FAIL hold_band: got %b want 00111", obs(0)); n_bad++; end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        tick(1, 0, 0, 0, 1, 1000);
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, 0, 10 * k, 1, 1000);
            n_cmp++;
            if (obs(1) !== expv(1)) begin
                $display("FAIL timeout_model cyc%0d: got %b want %b", k, obs(1), expv(1)); n_bad++;
            end
        end
        n_cmp++;
        if (obs(1) !== 5'b00110) begin $display("FAIL timeout_code: got %b want 00110", obs(1)); n_bad++; end
        n_cmp++;
        if (obs(0) !== 5'b10000) begin $display("FAIL timeout_long_busy: got %b want 10000", obs(0)); n_bad++; end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_abort_reset();
        tick(1, 0, 0, 100, 1, 900);
        tick(0, 0, 0, 110, 1, 900);
        tick(1, 1, 0, 120, 2, 0);
        n_cmp++;
        if (obs(0) !== 5'b00000) begin $display("FAIL abort_start: got %b want 00000", obs(0)); n_bad++; end
        tick(1, 0, 0, 100, 2, 10);
        tick(0, 0, 0, 95, 2, 10);
        #2 reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 5'b00000) begin $display("FAIL async_reset dut%0d: got %b want 00000", i, obs(i)); n_bad++; end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_fault_start();
        tick(1, 0, 0, 100, 1, 300);
        repeat (5) tick(0, 0, 0, 100, 1, 300);
        tick(1, 0, 0, 100, 1, 300);
        n_cmp++;
        if (obs(0) !== 5'b00101) begin $display("FAIL fault_start: got %b want 00101", obs(0)); n_bad++; end
        tick(0, 1, 0, 100, 1, 300);
        n_cmp++;
        if (obs(0) !== 5'b00101) begin $display("FAIL fault_abort: got %b want 00101", obs(0)); n_bad++; end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        int lv, md, tg;
        lv = 400;
        for (int k = 0; k < 600; k++) begin
            lv = lv + int'($urandom_range(0, 30)) - 13;
            if (lv < 0) lv = 0;
            if (lv > 1023) lv = 1023;
            md = int'($urandom_range(0, 3));
            tg = (md == 1) ? lv + int'($urandom_range(0, 200)) : lv - int'($urandom_range(0, 200));
            if (tg < 0) tg = 0;
            if (tg > 1023) tg = 1023;
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, lv, md, tg);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    $display("FAIL random dut%0d cyc%0d: got %b want %b", i, k, obs(i), expv(i)); n_bad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_progress();
        test_stall_clear(1, 100, 300, "fill_stall");
        test_stall_clear(2, 5, 0, "drain_underflow");
        test_leak();
        test_timeout();
        test_abort_reset();
        test_fault_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
